alu_rs: RTL

- ALU reservation station sitting directly downstream of the register file and dispatcher.
- Accepts one decoded instruction per cycle, with operands as (data, tag) pairs read from the register file.
- Snoops the CDB to fill pending operands and issues one ready instruction per cycle to the ALU.
- Holds up to DEPTH in-flight instructions and reports fullness back to the dispatcher.

---
 rtl/alu_rs_pkg.sv | 50 +++++
 rtl/rs_prio_enc.sv | 22 ++
 rtl/alu_rs.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, tag encoding, opcodes and the reservation-station entry layout.
package alu_rs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 6;

    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(0);

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_XOR  = 6'h05,
        OP_SLL  = 6'h06,
        OP_SRL  = 6'h07,
        OP_SRA  = 6'h08,
        OP_SLT  = 6'h09,
        OP_SLTU = 6'h0a
    } alu_op_e;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data1;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] data2;
        logic [TAG_W-1:0]  tag2;
        logic [TAG_W-1:0]  dest;
    } rs_entry_t;

    localparam rs_entry_t ENTRY_EMPTY = '{
        busy:  1'b0,
        op:    '0,
        data1: '0,
        tag1:  TAG_FREE,
        data2: '0,
        tag2:  TAG_FREE,
        dest:  '0
    };

    // True when a valid broadcast carries the tag an operand is waiting for.
    function automatic logic tag_hit(input logic en,
                                     input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] op_tag);
        return en && (op_tag != TAG_FREE) && (op_tag == bus_tag);
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and where.
module rs_prio_enc #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found_c) begin
                found_c = 1'b1;
                idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched instructions, snoops the CDB for
// pending operands and issues the lowest-index ready entry to the ALU.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enAlloc,
    input  logic [OP_W-1:0]   allocOp,
    input  logic [DATA_W-1:0] allocDataO,
    input  logic [TAG_W-1:0]  allocTagO,
    input  logic [DATA_W-1:0] allocDataT,
    input  logic [TAG_W-1:0]  allocTagT,
    input  logic [TAG_W-1:0]  allocDestTag,
    output logic              rsFull,
    input  logic              enCDB,
    input  logic [TAG_W-1:0]  CDBTag,
    input  logic [DATA_W-1:0] CDBData,
    input  logic              aluReady,
    output logic              aluEn,
    output logic [OP_W-1:0]   aluOp,
    output logic [DATA_W-1:0] aluSrc1,
    output logic [DATA_W-1:0] aluSrc2,
    output logic [TAG_W-1:0]  aluDestTag
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    rs_entry_t        rs [DEPTH];
    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;
    logic             do_alloc;
    logic             do_issue;
    rs_entry_t        alloc_entry;

    // Occupancy and readiness come from registered state only.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = rs[i].busy;
            ready_vec[i] = rs[i].busy && (rs[i].tag1 == TAG_FREE) && (rs[i].tag2 == TAG_FREE);
        end
    end

    rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .req     (~busy_vec),
        .found_c (free_found),
        .idx_c   (free_idx)
    );

    rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_issue_enc (
        .req     (ready_vec),
        .found_c (iss_found),
        .idx_c   (iss_idx)
    );

    assign rsFull   = ~free_found;
    assign do_alloc = enAlloc && free_found;
    assign do_issue = aluReady && iss_found;

    // New entry, with operands already captured if the CDB is broadcasting their tag now.
    always_comb begin
        alloc_entry       = ENTRY_EMPTY;
        alloc_entry.busy  = 1'b1;
        alloc_entry.op    = allocOp;
        alloc_entry.dest  = allocDestTag;
        alloc_entry.data1 = allocDataO;
        alloc_entry.tag1  = allocTagO;
        alloc_entry.data2 = allocDataT;
        alloc_entry.tag2  = allocTagT;
        if (tag_hit(enCDB, CDBTag, allocTagO)) begin
            alloc_entry.data1 = CDBData;
            alloc_entry.tag1  = TAG_FREE;
        end
        if (tag_hit(enCDB, CDBTag, allocTagT)) begin
            alloc_entry.data2 = CDBData;
            alloc_entry.tag2  = TAG_FREE;
        end
    end

    // Alloc targets a non-busy slot, so it never collides with snoop or issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) rs[i] <= ENTRY_EMPTY;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) rs[i] <= ENTRY_EMPTY;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rs[i].busy && tag_hit(enCDB, CDBTag, rs[i].tag1)) begin
                    rs[i].data1 <= CDBData;
                    rs[i].tag1  <= TAG_FREE;
                end
                if (rs[i].busy && tag_hit(enCDB, CDBTag, rs[i].tag2)) begin
                    rs[i].data2 <= CDBData;
                    rs[i].tag2  <= TAG_FREE;
                end
                if (do_issue && (iss_idx == IDX_W'(i))) rs[i].busy <= 1'b0;
                if (do_alloc && (free_idx == IDX_W'(i))) rs[i] <= alloc_entry;
            end
        end
    end

    // Issue register; payload holds its value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluEn      <= 1'b0;
            aluOp      <= '0;
            aluSrc1    <= '0;
            aluSrc2    <= '0;
            aluDestTag <= '0;
        end else if (flush) begin
            aluEn      <= 1'b0;
            aluOp      <= '0;
            aluSrc1    <= '0;
            aluSrc2    <= '0;
            aluDestTag <= '0;
        end else begin
            aluEn <= do_issue;
            if (do_issue) begin
                aluOp      <= rs[iss_idx].op;
                aluSrc1    <= rs[iss_idx].data1;
                aluSrc2    <= rs[iss_idx].data2;
                aluDestTag <= rs[iss_idx].dest;
            end
        end
    end

endmodule
